vga_text_renderer: RTL and testbench
====================================

Name: vga_text_renderer

Overview:
- Display-side consumer of the character VRAM read port: generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Fetches one character code per pixel from VRAM, then the matching glyph byte from the font ROM, and serialises it to RGB332.
- Draws a blinking underline cursor at a CPU-programmed cell.
- Fixed 5-cycle pipeline; syncs are delayed to match.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- COLS, 80, character columns (8 px wide)
- ROWS, 30, character rows (16 lines high)
- FG, 8'hFF, foreground RGB332
- BG, 8'h00, background RGB332
- BLINK_BIT, 5, frame-counter bit that gates the cursor

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  asynchronous, active-high reset
- vram_addr  out  13  character VRAM read address
- vram_data  in  8  character code; valid 1 cycle after vram_addr
- font_addr  out  12  {char_code[7:0], glyph_row[3:0]}
- font_data  in  8  glyph byte; bit 7 = leftmost pixel; valid 1 cycle after font_addr
- cursor_addr  in  13  VRAM address of the cursor cell
- cursor_en  in  1  cursor display enable
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  8  RGB332 pixel, {R[2:0], G[2:0], B[1:0]}
- frame_start  out  1  one-cycle pulse at h=0, v=0 (counter stage)

Behaviour:
- Reset (async, active-high) sets:
  - h_cnt=0, v_cnt=0, blink_cnt=0
  - all pipeline registers 0
  - hsync=1, vsync=1, rgb=0, frame_start=0
  - vram_addr=0, font_addr=0
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=800.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, where V_TOTAL=525.
  - blink_cnt (8-bit) increments when v_cnt and h_cnt wrap together, and wraps freely.
- Raw (stage-0) signals:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_n low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs_n low for the same window in v
- Stage 1 (registered):
  - vram_addr = row*COLS + col, where col=h_cnt[9:3] and row=v_cnt[8:4].
  - For COLS=80, compute row*80 as (row<<6)+(row<<4); no multiplier.
  - When not active, vram_addr = 0.
  - Also carry glyph_row=v_cnt[3:0], hx=h_cnt[2:0], active, hs_n, vs_n, and a cursor flag.
  - cursor flag = cursor_en && (computed addr == cursor_addr) && glyph_row>=14 && blink_cnt[BLINK_BIT]==0.
- Stage 2: vram_data returns; sideband signals delayed one cycle.
- Stage 3 (registered): font_addr = {vram_data, glyph_row}.
- Stage 4: font_data returns; sideband signals delayed.
- Stage 5 (registered outputs):
  - rgb = !active ? 8'h00 : (cursor || font_data[7-hx]) ? FG : BG
  - hsync and vsync come from the delayed hs_n/vs_n.
- Latency: rgb, hsync and vsync all lag the counters by exactly 5 cycles, so the screen image is unshifted relative to sync.
- frame_start is not delayed; it is a counter-stage pulse for CPU vblank handshaking.
- rgb must be 0 for every blanking pixel, including porches and sync.
- Glyph row and column wrap every 16 lines and every 8 pixels respectively, with no gaps.
- Address boundaries:
  - Maximum address 2399 (row 29, col 79).
  - Addresses 2400..8191 are never issued.
  - A cursor_addr >= 2400 never matches.
- cursor_addr may change at any time; it takes effect in the next stage-1 compare.
- Reset mid-frame: the outputs go inactive immediately (async). The first post-reset line starts at h=0, v=0, and frame_start pulses in the first cycle after reset deasserts.

Decomposition:
- Shared package:
  - VGA timing constants (H_TOTAL, V_TOTAL, porch and sync values)
  - COLS/ROWS
  - VRAM_AW=13, FONT_AW=12
  - RGB332 colour constants
- One natural sub-module: vga_timing_gen (h/v counters, active, raw syncs, frame_start, blink_cnt).
- The fetch and serialise pipeline stays in the top module.

Test Plan:
- Post-reset timing:
  - hsync falls 5+656 cycles after rst deasserts and stays low for exactly 96 cycles.
  - hsync period is 800 cycles.
  - vsync is low for 1600 cycles per 420000-cycle frame.
- Address walk:
  - At h=632, v=464, vram_addr = 2399 on the next cycle.
  - At h=0, v=16, vram_addr = 80.
  - During blanking, vram_addr = 0.
- Glyph path: model returns vram_data=8'h41 and font_data=8'b1000_0001.
  - font_addr = 12'h41x for glyph row x.
  - rgb = FF at hx 0 and 7, 00 at hx 1..6.
- Cursor: cursor_addr=0, cursor_en=1, blink_cnt bit5=0.
  - Lines 14-15, pixels 0-7: rgb = FF.
  - Lines 0-13 of the same cell follow the glyph.
  - After 32 frames the cursor is hidden.
  - cursor_addr=3000 never shows.
- Blanking: font_data forced to 8'hFF -> rgb = 0 for h_cnt 640..799 and v_cnt 480..524, allowing for the 5-cycle offset.
- Async reset mid-line (h=300, v=200):
  - hsync/vsync = 1 and rgb = 0 in the same cycle.
  - After release, frame_start pulses once, then timing restarts as in the first scenario.

Source files
------------

// File: rtl/vga_text_renderer_pkg.sv
// Shared constants and types for the VGA text renderer.
// Holds 640x480@60 timing, text grid geometry, bus widths and colours.
package vga_text_renderer_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = 800;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = 525;

    localparam int COLS       = 80;
    localparam int ROWS       = 30;
    localparam int VRAM_AW    = 13;
    localparam int FONT_AW    = 12;
    localparam int VRAM_DEPTH = COLS * ROWS;

    localparam logic [7:0] RGB_FG = 8'hFF;
    localparam logic [7:0] RGB_BG = 8'h00;
    localparam int CURSOR_BLINK_BIT = 5;

    // Per-pixel sideband that travels alongside the memory fetches.
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       cursor;
        logic [2:0] hx;
    } side_t;

endpackage

// File: rtl/vga_text_renderer_if.sv
// Memory-side bus of the renderer: VRAM and font ROM read ports.
// master: renderer (drives addresses); slave: memories (return data).
interface vga_text_renderer_if;

    logic [vga_text_renderer_pkg::VRAM_AW-1:0] vram_addr;
    logic [7:0]                                vram_data;
    logic [vga_text_renderer_pkg::FONT_AW-1:0] font_addr;
    logic [7:0]                                font_data;

    modport master (
        output vram_addr,
        output font_addr,
        input  vram_data,
        input  font_data
    );

    modport slave (
        input  vram_addr,
        input  font_addr,
        output vram_data,
        output font_data
    );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA counter stage: h/v counters, raw active/sync flags, blink counter.
// Ports: clk, rst in; h_cnt, row, gy, active, hs, vs, blink, frame_start out.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BLINK_BIT = 5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h_cnt,
    output logic [4:0] row,
    output logic [3:0] gy,
    output logic       active,
    output logic       hs,
    output logic       vs,
    output logic       blink,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] v_cnt;
    logic [7:0] blink_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            blink_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt     <= '0;
                blink_cnt <= blink_cnt + 8'd1;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign row    = v_cnt[8:4];
    assign gy     = v_cnt[3:0];
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign blink  = blink_cnt[BLINK_BIT];

    // Gated by rst so the pulse is low while held in reset and
    // appears in the very first cycle after release.
    assign frame_start = !rst && (h_cnt == 10'd0) && (v_cnt == 10'd0);

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode VGA renderer: VRAM -> font ROM -> RGB332, 5-cycle pipeline.
// Ports: clk, rst, mem (VRAM/font bus), cursor_addr/en in; hsync, vsync, rgb, frame_start out.
module vga_text_renderer
    import vga_text_renderer_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter logic [7:0] FG      = RGB_FG,
    parameter logic [7:0] BG      = RGB_BG,
    parameter int BLINK_BIT       = CURSOR_BLINK_BIT
) (
    input  logic               clk,
    input  logic               rst,
    vga_text_renderer_if.master mem,
    input  logic [VRAM_AW-1:0] cursor_addr,
    input  logic               cursor_en,
    output logic               hsync,
    output logic               vsync,
    output logic [7:0]         rgb,
    output logic               frame_start
);

    logic [9:0] h_cnt;
    logic [4:0] row;
    logic [3:0] gy;
    logic       raw_active;
    logic       raw_hs;
    logic       raw_vs;
    logic       blink;

    vga_timing_gen #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .BLINK_BIT (BLINK_BIT)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .row         (row),
        .gy          (gy),
        .active      (raw_active),
        .hs          (raw_hs),
        .vs          (raw_vs),
        .blink       (blink),
        .frame_start (frame_start)
    );

    logic [6:0]         col;
    logic [VRAM_AW-1:0] cell_addr;
    logic               cur_hit;

    assign col = h_cnt[9:3];

    // row*80 as row*64 + row*16, no multiplier.
    assign cell_addr = {2'b00, row, 6'b0}
                     + {4'b0000, row, 4'b0}
                     + {6'b0, col};

    // Underline covers the last two glyph rows of the cell.
    assign cur_hit = cursor_en
                  && raw_active
                  && (cell_addr == cursor_addr)
                  && (cursor_addr < VRAM_AW'(VRAM_DEPTH))
                  && (gy[3:1] == 3'b111)
                  && !blink;

    side_t      s1, s2, s3, s4;
    logic [3:0] gy1, gy2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            s4            <= '0;
            gy1           <= '0;
            gy2           <= '0;
            mem.vram_addr <= '0;
            mem.font_addr <= '0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            rgb           <= '0;
        end else begin
            s1 <= '{active: raw_active, hs: raw_hs, vs: raw_vs,
                    cursor: cur_hit, hx: h_cnt[2:0]};
            gy1           <= gy;
            mem.vram_addr <= raw_active ? cell_addr : '0;

            s2  <= s1;
            gy2 <= gy1;

            s3            <= s2;
            mem.font_addr <= {mem.vram_data, gy2};

            s4 <= s3;

            hsync <= ~s4.hs;
            vsync <= ~s4.vs;
            // Bit 7 is the leftmost pixel, so index with 7-hx == ~hx.
            if (!s4.active)
                rgb <= 8'h00;
            else if (s4.cursor || mem.font_data[~s4.hx])
                rgb <= FG;
            else
                rgb <= BG;
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench for vga_text_renderer.
// Vertical timing is shortened (36 lines/frame) so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_text_renderer;
    import vga_text_renderer_pkg::*;

    localparam int HT = 800;
    localparam int VT = 36;
    localparam int FRAME = HT * VT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [VRAM_AW-1:0] cursor_addr = '0;
    logic               cursor_en = 1'b1;
    logic               hsync;
    logic               vsync;
    logic [7:0]         rgb;
    logic               frame_start;
    logic               force_ff = 1'b0;
    logic               mon_en = 1'b1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vs_low = 0;

    vga_text_renderer_if bus ();

    vga_text_renderer #(
        .V_ACTIVE  (32),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1),
        .BLINK_BIT (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (bus),
        .cursor_addr (cursor_addr),
        .cursor_en   (cursor_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // Memory models: one-cycle read latency.
    always @(posedge clk) begin
        bus.vram_data <= (bus.vram_addr < 13'd2400) ? 8'h41 : 8'h00;
        if (force_ff)
            bus.font_data <= 8'hFF;
        else if (bus.font_addr[11:4] == 8'h41)
            bus.font_data <= 8'b1000_0001;
        else
            bus.font_data <= 8'h00;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mon_en && !rst && cyc >= 1 && cyc <= FRAME && vsync === 1'b0)
            vs_low <= vs_low + 1;
    end

    typedef enum int {S_VADDR, S_FADDR, S_RGB, S_HS, S_VS, S_FS} sig_e;

    typedef struct {
        string name;
        sig_e  sig;
        int    h;
        int    v;
        int    exp;
        int    cur;
        int    n;
    } vec_t;

    vec_t vt[40];
    int   nv = 0;

    function automatic int lag_of(sig_e s);
        case (s)
            S_VADDR: return 1;
            S_FADDR: return 3;
            S_FS:    return 0;
            default: return 5;
        endcase
    endfunction

    function automatic int sample(sig_e s);
        case (s)
            S_VADDR: return int'(bus.vram_addr);
            S_FADDR: return int'(bus.font_addr);
            S_RGB:   return int'(rgb);
            S_HS:    return int'(hsync);
            S_VS:    return int'(vsync);
            default: return int'(frame_start);
        endcase
    endfunction

    task automatic add(string nm, sig_e s, int h, int v, int e, int c);
        vt[nv] = '{name: nm, sig: s, h: h, v: v, exp: e, cur: c,
                   n: v * HT + h + lag_of(s)};
        nv++;
    endtask

    task automatic check(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_to(int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tmp;
        int   errs;
        int   t0;

        add("fs_h1",        S_FS,    1,   0,  0,      0);
        add("vaddr_col1",   S_VADDR, 8,   0,  1,      0);
        add("hs_655",       S_HS,    655, 1,  1,      0);
        add("hs_656",       S_HS,    656, 1,  0,      0);
        add("hs_751",       S_HS,    751, 1,  0,      0);
        add("hs_752",       S_HS,    752, 1,  1,      0);
        add("rgb_hx0",      S_RGB,   8,   2,  'hFF,   0);
        add("rgb_hx1",      S_RGB,   9,   2,  'h00,   0);
        add("rgb_hx6",      S_RGB,   14,  2,  'h00,   0);
        add("rgb_hx7",      S_RGB,   15,  2,  'hFF,   0);
        add("faddr_r3",     S_FADDR, 16,  3,  'h413,  0);
        add("faddr_r12",    S_FADDR, 16,  12, 'h41C,  0);
        add("rgb_l13_hx0",  S_RGB,   0,   13, 'hFF,   0);
        add("rgb_l13_hx3",  S_RGB,   3,   13, 'h00,   0);
        add("cur_l14",      S_RGB,   3,   14, 'hFF,   0);
        add("cur_l14_c1",   S_RGB,   11,  14, 'h00,   0);
        add("cur_l15",      S_RGB,   3,   15, 'hFF,   0);
        add("cur_l15_hx7",  S_RGB,   7,   15, 'hFF,   0);
        add("vaddr_80",     S_VADDR, 0,   16, 80,     0);
        add("vaddr_159",    S_VADDR, 632, 16, 159,    0);
        add("vaddr_hblank", S_VADDR, 640, 16, 0,      0);
        add("cur_moved",    S_RGB,   3,   30, 'hFF,   80);
        add("cur_3000",     S_RGB,   3,   31, 'h00,   3000);
        add("vaddr_vblank", S_VADDR, 100, 33, 0,      3000);
        add("vs_v32",       S_VS,    799, 32, 1,      3000);
        add("vs_v33",       S_VS,    0,   33, 0,      3000);
        add("vs_v34",       S_VS,    799, 34, 0,      3000);
        add("vs_v35",       S_VS,    0,   35, 1,      3000);
        add("fs_frame1",    S_FS,    0,   36, 1,      3000);
        add("f1_glyph",     S_RGB,   0,   50, 'hFF,   0);
        add("f1_cur_hide",  S_RGB,   3,   50, 'h00,   0);

        for (int i = 0; i < nv; i++)
            for (int j = 0; j < nv - 1 - i; j++)
                if (vt[j].n > vt[j + 1].n) begin
                    tmp       = vt[j];
                    vt[j]     = vt[j + 1];
                    vt[j + 1] = tmp;
                end

        repeat (3) @(negedge clk);
        check("rst_vaddr", int'(bus.vram_addr), 0);
        check("rst_faddr", int'(bus.font_addr), 0);
        check("rst_rgb",   int'(rgb),           0);
        check("rst_hsync", int'(hsync),         1);
        check("rst_vsync", int'(vsync),         1);
        check("rst_fs",    int'(frame_start),   0);

        rst = 1'b0;
        #1;
        check("fs_first", int'(frame_start), 1);

        for (int i = 0; i < nv; i++) begin
            cursor_addr = 13'(vt[i].cur);
            wait_to(vt[i].n);
            check(vt[i].name, sample(vt[i].sig), vt[i].exp);
        end

        check("vs_low_cycles", vs_low, 1600);

        force_ff = 1'b1;
        errs = 0;
        for (int h = 0; h < 640; h++) begin
            wait_to(52 * HT + h + 5);
            if (rgb !== 8'hFF) errs++;
        end
        check("active_ff_px", errs, 0);
        errs = 0;
        for (int h = 640; h < HT; h++) begin
            wait_to(52 * HT + h + 5);
            if (rgb !== 8'h00) errs++;
        end
        check("hblank_px", errs, 0);
        errs = 0;
        for (int n = 68 * HT + 5; n <= 71 * HT + 799 + 5; n++) begin
            wait_to(n);
            if (rgb !== 8'h00) errs++;
        end
        check("vblank_px", errs, 0);

        mon_en = 1'b0;
        wait_to(2 * FRAME + 2 * HT + 300);
        check("pre_rst_rgb", int'(rgb), 'hFF);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rgb",   int'(rgb),           0);
        check("mid_rst_hsync", int'(hsync),         1);
        check("mid_rst_vsync", int'(vsync),         1);
        check("mid_rst_fs",    int'(frame_start),   0);
        check("mid_rst_vaddr", int'(bus.vram_addr), 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_fs_pulse", int'(frame_start), 1);
        @(negedge clk);
        check("post_fs_clear", int'(frame_start), 0);

        while (hsync !== 1'b0 && cyc < 3000) @(negedge clk);
        check("hs_fall_delay", cyc, 661);
        t0 = cyc;
        while (hsync !== 1'b1 && cyc < t0 + 2000) @(negedge clk);
        check("hs_low_width", cyc - t0, 96);
        while (hsync !== 1'b0 && cyc < t0 + 2000) @(negedge clk);
        check("hs_period", cyc - t0, 800);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
